// File: rtl/branch_predictor_table.sv
// branch_predictor_table: table of saturating direction counters, bimodal or gshare indexed.
// Revision 1.0 - initial release
`default_nettype none

module branch_predictor_table #(
  parameter int PC_WIDTH   = 16,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int RESET_CTR  = 0,
  parameter int GHR_BITS   = 0,
  parameter int PERF_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_pred_taken,
  output logic [PERF_BITS-1:0]  perf_branches,
  output logic [PERF_BITS-1:0]  perf_misses,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] ghr
);

  localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int ENTRIES = 2 ** INDEX_BITS;

  localparam logic [CTR_BITS-1:0]  c_reset_ctr = CTR_BITS'(RESET_CTR);
  localparam logic [CTR_BITS-1:0]  c_ctr_max   = '1;
  localparam logic [PERF_BITS-1:0] c_perf_max  = '1;

  logic [CTR_BITS-1:0]   r_table [ENTRIES];
  logic [GW-1:0]         r_ghr;
  logic [PERF_BITS-1:0]  r_branches;
  logic [PERF_BITS-1:0]  r_misses;
  logic [INDEX_BITS-1:0] w_base;
  logic [INDEX_BITS-1:0] w_idx;

  // Instructions are halfword aligned, so PC bit 0 carries no index information.
  assign w_base = pred_pc[INDEX_BITS:1];

  generate
    if (GHR_BITS == 0) begin : g_bimodal
      assign w_idx = w_base;
      assign r_ghr = '0;
    end else begin : g_gshare
      assign w_idx = w_base ^ INDEX_BITS'(r_ghr);

      if (GHR_BITS == 1) begin : g_ghr_one
        always_ff @(posedge clk or posedge rst) begin
          if (rst)
            r_ghr <= '0;
          else if (upd_valid)
            r_ghr <= upd_taken;
        end
      end else begin : g_ghr_shift
        always_ff @(posedge clk or posedge rst) begin
          if (rst)
            r_ghr <= '0;
          else if (upd_valid)
            r_ghr <= {r_ghr[GW-2:0], upd_taken};
        end
      end
    end
  endgenerate

  // Reads registered state only: a same-cycle update is seen one cycle later.
  assign pred_idx   = w_idx;
  assign pred_taken = r_table[w_idx][CTR_BITS-1];
  assign ghr        = r_ghr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_table[i] <= c_reset_ctr;
    end else if (upd_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (upd_idx == INDEX_BITS'(i)) begin
          if (upd_taken && (r_table[i] != c_ctr_max))
            r_table[i] <= r_table[i] + CTR_BITS'(1);
          else if (!upd_taken && (r_table[i] != '0))
            r_table[i] <= r_table[i] - CTR_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branches <= '0;
      r_misses   <= '0;
    end else if (upd_valid) begin
      if (r_branches != c_perf_max)
        r_branches <= r_branches + PERF_BITS'(1);
      if ((upd_pred_taken != upd_taken) && (r_misses != c_perf_max))
        r_misses <= r_misses + PERF_BITS'(1);
    end
  end

  assign perf_branches = r_branches;
  assign perf_misses   = r_misses;

  generate
    if (INDEX_BITS + 1 < PC_WIDTH) begin : g_unused_hi
      logic w_unused_pc;
      assign w_unused_pc = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+1], pred_pc[0]};
    end else begin : g_unused_lo
      logic w_unused_pc;
      assign w_unused_pc = pred_pc[0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: checks bimodal, gshare and narrow-perf configurations against a model.
// Revision 1.0 - initial release
`default_nettype none

module tb_branch_predictor_table;

  logic        clk;
  logic        rst;
  logic [15:0] pred_pc;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred_taken;

  logic        tk0, tk1, tk2;
  logic [3:0]  idx0, idx1, idx2;
  logic [15:0] br0, br1, miss0, miss1;
  logic [2:0]  br2, miss2;
  logic        ghr0, ghr2;
  logic [1:0]  ghr1;

  int tests = 0;
  int fails = 0;

  branch_predictor_table dut0 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(tk0), .pred_idx(idx0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .perf_branches(br0), .perf_misses(miss0), .ghr(ghr0)
  );

  branch_predictor_table #(.GHR_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(tk1), .pred_idx(idx1),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .perf_branches(br1), .perf_misses(miss1), .ghr(ghr1)
  );

  branch_predictor_table #(.PERF_BITS(3)) dut2 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(tk2), .pred_idx(idx2),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .perf_branches(br2), .perf_misses(miss2), .ghr(ghr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: counters as plain integers in 0..3, history as an integer modulo 2^GHR_BITS.
  int m_tbl  [3][16];
  int m_ghr  [3];
  int m_br   [3];
  int m_miss [3];
  int c_ghr_bits [3] = '{0, 2, 0};
  int c_perf_max [3] = '{65535, 65535, 7};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 16; i++) m_tbl[d][i] <= 0;
        m_ghr[d]  <= 0;
        m_br[d]   <= 0;
        m_miss[d] <= 0;
      end
    end else if (upd_valid) begin
      for (int d = 0; d < 3; d++) begin
        if (upd_taken) m_tbl[d][upd_idx] <= (m_tbl[d][upd_idx] < 3) ? m_tbl[d][upd_idx] + 1 : 3;
        else           m_tbl[d][upd_idx] <= (m_tbl[d][upd_idx] > 0) ? m_tbl[d][upd_idx] - 1 : 0;
        if (c_ghr_bits[d] > 0)
          m_ghr[d] <= (m_ghr[d] * 2 + int'(upd_taken)) % (1 << c_ghr_bits[d]);
        m_br[d] <= (m_br[d] < c_perf_max[d]) ? m_br[d] + 1 : m_br[d];
        if (upd_taken != upd_pred_taken)
          m_miss[d] <= (m_miss[d] < c_perf_max[d]) ? m_miss[d] + 1 : m_miss[d];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input int tk, input int idx, input int g,
                           input int br, input int miss);
    int e_idx;
    e_idx = (int'(pred_pc) / 2) % 16;
    if (c_ghr_bits[d] > 0) e_idx = e_idx ^ m_ghr[d];
    check($sformatf("d%0d_idx", d),  idx,  e_idx);
    check($sformatf("d%0d_tk", d),   tk,   (m_tbl[d][e_idx] >= 2) ? 1 : 0);
    check($sformatf("d%0d_ghr", d),  g,    m_ghr[d]);
    check($sformatf("d%0d_br", d),   br,   m_br[d]);
    check($sformatf("d%0d_miss", d), miss, m_miss[d]);
  endtask

  always @(negedge clk) begin
    check_dut(0, int'(tk0), int'(idx0), int'(ghr0), int'(br0), int'(miss0));
    check_dut(1, int'(tk1), int'(idx1), int'(ghr1), int'(br1), int'(miss1));
    check_dut(2, int'(tk2), int'(idx2), int'(ghr2), int'(br2), int'(miss2));
  end

  task automatic upd(input int idx, input bit t, input bit p);
    upd_idx        = 4'(idx);
    upd_taken      = t;
    upd_pred_taken = p;
    upd_valid      = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
  endtask

  int exp_t [4] = '{0, 1, 1, 1};
  int exp_n [4] = '{1, 0, 0, 0};

  initial begin
    rst = 1'b1; pred_pc = '0; upd_valid = 1'b0; upd_idx = '0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state and index sweep
    check("rst_br", int'(br0), 0);
    check("rst_miss", int'(miss0), 0);
    check("rst_ghr", int'(ghr1), 0);
    for (int i = 0; i < 16; i++) begin
      pred_pc = 16'(2 * i);
      #1;
      check("sweep_tk", int'(tk0), 0);
      check("sweep_idx", int'(idx0), i);
    end

    // Bimodal training and saturation on idx 3
    pred_pc = 16'h0006;
    #1;
    for (int k = 0; k < 4; k++) begin
      upd(3, 1'b1, tk0);
      check("bim_taken", int'(tk0), exp_t[k]);
    end
    for (int k = 0; k < 4; k++) begin
      upd(3, 1'b0, tk0);
      check("bim_not_taken", int'(tk0), exp_n[k]);
    end

    // Isolation and aliasing around idx 5
    repeat (3) upd(5, 1'b1, 1'b0);
    pred_pc = 16'h0008; #1; check("iso_idx4", int'(tk0), 0);
    pred_pc = 16'h000C; #1; check("iso_idx6", int'(tk0), 0);
    pred_pc = 16'h000A; #1; check("train_idx5", int'(tk0), 1);
    pred_pc = 16'h002A; #1; check("alias_idx5", int'(tk0), 1);
    check("alias_idx", int'(idx0), 5);

    // Same-cycle predict/update hazard on idx 2
    upd(2, 1'b1, 1'b0);
    pred_pc = 16'h0004;
    upd_idx = 4'd2; upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_valid = 1'b1;
    #1;
    check("hazard_before", int'(tk0), 0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check("hazard_after", int'(tk0), 1);

    // Gshare indexing
    rst = 1'b1; #2; rst = 1'b0; #1;
    repeat (3) upd(0, 1'b1, 1'b0);
    check("gs_ghr", int'(ghr1), 3);
    pred_pc = 16'h0000; #1; check("gs_idx_pc0", int'(idx1), 3);
    pred_pc = 16'h0006; #1; check("gs_idx_pc6", int'(idx1), 0);
    check("bim_ghr_tied", int'(ghr0), 0);

    // Perf counters, saturation and asynchronous reset
    rst = 1'b1; #2; rst = 1'b0; #1;
    upd(1, 1'b1, 1'b1);
    upd(1, 1'b0, 1'b1);
    upd(1, 1'b1, 1'b1);
    upd(1, 1'b0, 1'b0);
    upd(1, 1'b1, 1'b0);
    check("perf_br5", int'(br0), 5);
    check("perf_miss2", int'(miss0), 2);
    repeat (4) upd(1, 1'b1, 1'b1);
    check("perf_br9", int'(br0), 9);
    check("perf3_sat", int'(br2), 7);
    check("perf3_miss", int'(miss2), 2);
    pred_pc = 16'h0002; #1;
    check("pre_rst_tk", int'(tk0), 1);
    check("pre_rst_ghr", int'(ghr1), 3);
    rst = 1'b1; #1;
    check("arst_br", int'(br0), 0);
    check("arst_miss", int'(miss0), 0);
    check("arst_ghr", int'(ghr1), 0);
    check("arst_tk", int'(tk0), 0);
    check("arst_br3", int'(br2), 0);
    upd_idx = 4'd1; upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check("rst_drop_br", int'(br0), 0);
    check("rst_drop_tk", int'(tk0), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
